// File: rtl/seq_scan_ctrl_if.sv
// Handshake and data bundle between a scan requester and seq_scan_ctrl.
// The requester owns start/abort/din. The controller drives every status output.
interface seq_scan_ctrl_if #(
   parameter int unsigned WORD_W = 16,
   parameter int unsigned CNT_W  = 5
);
   logic              start;
   logic              abort;
   logic [WORD_W-1:0] din;
   logic              busy;
   logic              det_rst;
   logic              ser_bit;
   logic              ser_valid;
   logic              match_pulse;
   logic [CNT_W-1:0]  match_cnt;
   logic              done;

   modport master (
      output start, abort, din,
      input  busy, det_rst, ser_bit, ser_valid, match_pulse, match_cnt, done
   );

   modport slave (
      input  start, abort, din,
      output busy, det_rst, ser_bit, ser_valid, match_pulse, match_cnt, done
   );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Scan controller: pulses the detector reset, shifts a captured word out MSB-first,
// and counts overlapping hits of PAT so the external detector can be cross-checked.
module seq_scan_ctrl #(
   parameter int unsigned       WORD_W = 16,
   parameter int unsigned       PAT_W  = 5,
   parameter logic [PAT_W-1:0]  PAT    = 5'b11001,
   parameter int unsigned       CNT_W  = 5
) (
   input logic           CLK,
   input logic           RESET,
   seq_scan_ctrl_if.slave bus
);

   localparam int unsigned BC_W = $clog2(WORD_W + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CLR   = 2'd1;
   localparam logic [1:0] S_SHIFT = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]        state;
   logic [WORD_W-1:0] sreg;
   // Only PAT_W-1 history bits are stored; the newest bit comes straight from sreg.
   logic [PAT_W-2:0]  hist;
   logic [BC_W-1:0]   bitcnt;
   logic              match_pulse;
   logic [CNT_W-1:0]  match_cnt;

   logic [PAT_W-1:0]  hist_next;
   logic              hit;
   logic              last_bit;

   always_comb begin
      hist_next = {hist, sreg[WORD_W-1]};
      hit       = (bitcnt >= BC_W'(PAT_W - 1)) && (hist_next == PAT);
      last_bit  = (bitcnt == BC_W'(WORD_W - 1));
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= S_IDLE;
         sreg        <= '0;
         hist        <= '0;
         bitcnt      <= '0;
         match_pulse <= 1'b0;
         match_cnt   <= '0;
      end else begin
         match_pulse <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  sreg  <= bus.din;
                  state <= S_CLR;
               end
            end
            S_CLR: begin
               hist      <= '0;
               bitcnt    <= '0;
               match_cnt <= '0;
               state     <= bus.abort ? S_IDLE : S_SHIFT;
               if (bus.abort) begin
                  sreg <= '0;
               end
            end
            S_SHIFT: begin
               if (bus.abort) begin
                  // Abort freezes the partial count and drops the unsent bits.
                  sreg  <= '0;
                  state <= S_IDLE;
               end else begin
                  sreg   <= {sreg[WORD_W-2:0], 1'b0};
                  hist   <= hist_next[PAT_W-2:0];
                  bitcnt <= bitcnt + BC_W'(1);
                  if (hit) begin
                     match_pulse <= 1'b1;
                     if (match_cnt != '1) begin
                        match_cnt <= match_cnt + CNT_W'(1);
                     end
                  end
                  if (last_bit) begin
                     state <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state == S_CLR) || (state == S_SHIFT);
   assign bus.det_rst     = (state == S_CLR);
   assign bus.ser_valid   = (state == S_SHIFT);
   assign bus.done        = (state == S_DONE);
   assign bus.ser_bit     = sreg[WORD_W-1];
   assign bus.match_pulse = match_pulse;
   assign bus.match_cnt   = match_cnt;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl: default-pattern instance plus a small
// saturating instance (pattern 10, 2-bit counter) sharing clock and reset.
module tb_seq_scan_ctrl;

   logic CLK;
   logic RESET;

   int errors = 0;
   int checks = 0;

   seq_scan_ctrl_if #(.WORD_W(16), .CNT_W(5)) if0 ();
   seq_scan_ctrl_if #(.WORD_W(16), .CNT_W(2)) if1 ();

   seq_scan_ctrl #(.WORD_W(16), .PAT_W(5), .PAT(5'b11001), .CNT_W(5)) u0 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if0)
   );

   seq_scan_ctrl #(.WORD_W(16), .PAT_W(2), .PAT(2'b10), .CNT_W(2)) u1 (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (if1)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [15:0] din;
      bit          poke;
      logic [15:0] exp_mask;
      int          exp_cnt;
   } vec_t;

   task automatic chk(input string tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s.%s: got %0h expected %0h", tag, nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Full scan on if0; mask bit (16-j) records a pulse attributed to bit j.
   task automatic run_scan(input logic [15:0] d, input bit poke, input logic [15:0] exp_mask,
                           input int exp_cnt, input string tag);
      logic [15:0] mask;
      int nvalid;
      mask   = '0;
      nvalid = 0;
      if0.start = 1'b1;
      if0.din   = d;
      tick();
      if0.start = 1'b0;
      if0.din   = '0;
      chk(tag, "clr_det_rst", if0.det_rst, 1);
      chk(tag, "clr_busy", if0.busy, 1);
      chk(tag, "clr_ser_valid", if0.ser_valid, 0);
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (if0.ser_valid) nvalid++;
         chk(tag, "ser_bit", if0.ser_bit, d[16-i]);
         chk(tag, "shift_done", if0.done, 0);
         if (i == 1) chk(tag, "shift_det_rst", if0.det_rst, 0);
         if (i >= 2 && if0.match_pulse) mask[17-i] = 1'b1;
         if (poke && i == 4) begin
            if0.start = 1'b1;
            if0.din   = 16'hFFFF;
         end else begin
            if0.start = 1'b0;
         end
      end
      tick();
      chk(tag, "done", if0.done, 1);
      chk(tag, "done_busy", if0.busy, 0);
      chk(tag, "done_ser_valid", if0.ser_valid, 0);
      if (if0.match_pulse) mask[0] = 1'b1;
      chk(tag, "pulse_mask", mask, exp_mask);
      chk(tag, "valid_cycles", nvalid, 16);
      chk(tag, "done_cnt", if0.match_cnt, exp_cnt);
      if (poke) if0.start = 1'b1;
      tick();
      if0.start = 1'b0;
      chk(tag, "idle_done", if0.done, 0);
      chk(tag, "idle_busy", if0.busy, 0);
      chk(tag, "idle_pulse", if0.match_pulse, 0);
      chk(tag, "idle_cnt", if0.match_cnt, exp_cnt);
      tick();
      chk(tag, "no_queue_busy", if0.busy, 0);
      chk(tag, "no_queue_det_rst", if0.det_rst, 0);
   endtask

   initial begin
      vec_t vecs[7];
      int pulses;
      int dones;

      vecs[0] = '{din: 16'hC800, poke: 1'b0, exp_mask: 16'h0800, exp_cnt: 1};
      vecs[1] = '{din: 16'hCC80, poke: 1'b0, exp_mask: 16'h0880, exp_cnt: 2};
      vecs[2] = '{din: 16'h0000, poke: 1'b0, exp_mask: 16'h0000, exp_cnt: 0};
      vecs[3] = '{din: 16'h6640, poke: 1'b1, exp_mask: 16'h0440, exp_cnt: 2};
      vecs[4] = '{din: 16'h0019, poke: 1'b0, exp_mask: 16'h0001, exp_cnt: 1};
      vecs[5] = '{din: 16'hCCCC, poke: 1'b1, exp_mask: 16'h0888, exp_cnt: 3};
      vecs[6] = '{din: 16'hFFFF, poke: 1'b0, exp_mask: 16'h0000, exp_cnt: 0};

      RESET = 1'b1;
      if0.start = 1'b0; if0.abort = 1'b0; if0.din = '0;
      if1.start = 1'b0; if1.abort = 1'b0; if1.din = '0;
      repeat (3) tick();
      chk("reset", "busy", if0.busy, 0);
      chk("reset", "det_rst", if0.det_rst, 0);
      chk("reset", "ser_bit", if0.ser_bit, 0);
      chk("reset", "ser_valid", if0.ser_valid, 0);
      chk("reset", "match_pulse", if0.match_pulse, 0);
      chk("reset", "match_cnt", if0.match_cnt, 0);
      chk("reset", "done", if0.done, 0);
      chk("reset", "sat_cnt", if1.match_cnt, 0);
      RESET = 1'b0;
      tick();

      for (int v = 0; v < 7; v++) begin
         run_scan(vecs[v].din, vecs[v].poke, vecs[v].exp_mask, vecs[v].exp_cnt, $sformatf("vec%0d", v));
      end

      // Straddle + back-to-back: start held high across both scans.
      if0.start = 1'b1;
      if0.din   = 16'h000C;
      pulses    = 0;
      tick();
      chk("b2b", "clr1", if0.det_rst, 1);
      for (int c = 2; c <= 18; c++) begin
         tick();
         if (c >= 3 && if0.match_pulse) pulses++;
         if (c == 18) begin
            chk("b2b", "done1", if0.done, 1);
            chk("b2b", "cnt1", if0.match_cnt, 0);
            if0.din = 16'h8000;
         end
      end
      tick();
      chk("b2b", "gap_busy", if0.busy, 0);
      chk("b2b", "gap_det_rst", if0.det_rst, 0);
      tick();
      chk("b2b", "clr2", if0.det_rst, 1);
      if0.start = 1'b0;
      for (int c = 2; c <= 18; c++) begin
         tick();
         if (c >= 3 && if0.match_pulse) pulses++;
         if (c == 18) begin
            chk("b2b", "done2", if0.done, 1);
            chk("b2b", "cnt2", if0.match_cnt, 0);
         end
      end
      chk("b2b", "pulses", pulses, 0);
      tick();

      // Abort during the 6th SHIFT cycle of CC80.
      if0.start = 1'b1;
      if0.din   = 16'hCC80;
      tick();
      if0.start = 1'b0;
      for (int i = 1; i <= 6; i++) tick();
      chk("abort", "bit5_pulse", if0.match_pulse, 1);
      if0.abort = 1'b1;
      tick();
      if0.abort = 1'b0;
      chk("abort", "busy", if0.busy, 0);
      chk("abort", "ser_valid", if0.ser_valid, 0);
      chk("abort", "done", if0.done, 0);
      chk("abort", "cnt", if0.match_cnt, 1);
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (if0.done) dones++;
      end
      chk("abort", "no_done", dones, 0);
      chk("abort", "cnt_held", if0.match_cnt, 1);

      // start beats abort in IDLE; abort then takes effect in CLR.
      if0.start = 1'b1;
      if0.abort = 1'b1;
      if0.din   = 16'hC800;
      tick();
      if0.start = 1'b0;
      chk("abort_clr", "start_wins", if0.det_rst, 1);
      tick();
      if0.abort = 1'b0;
      chk("abort_clr", "busy", if0.busy, 0);
      chk("abort_clr", "done", if0.done, 0);
      tick();

      // RESET mid-SHIFT after a hit, on a cycle where ser_bit is 1.
      if0.start = 1'b1;
      if0.din   = 16'hCC80;
      tick();
      if0.start = 1'b0;
      for (int i = 1; i <= 9; i++) tick();
      chk("rst_mid", "pre_ser_bit", if0.ser_bit, 1);
      chk("rst_mid", "pre_cnt", if0.match_cnt, 1);
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("rst_mid", "busy", if0.busy, 0);
      chk("rst_mid", "det_rst", if0.det_rst, 0);
      chk("rst_mid", "ser_bit", if0.ser_bit, 0);
      chk("rst_mid", "ser_valid", if0.ser_valid, 0);
      chk("rst_mid", "match_pulse", if0.match_pulse, 0);
      chk("rst_mid", "match_cnt", if0.match_cnt, 0);
      chk("rst_mid", "done", if0.done, 0);
      tick();
      chk("rst_mid", "stays_idle", if0.busy, 0);

      // Saturation on the 2-bit-counter instance: AAAA gives 8 hits of "10".
      if1.start = 1'b1;
      if1.din   = 16'hAAAA;
      pulses    = 0;
      tick();
      if1.start = 1'b0;
      chk("sat", "clr", if1.det_rst, 1);
      for (int c = 2; c <= 18; c++) begin
         tick();
         if (c >= 3 && if1.match_pulse) pulses++;
         if (c == 12) chk("sat", "mid_cnt", if1.match_cnt, 3);
         if (c == 18) begin
            chk("sat", "done", if1.done, 1);
            chk("sat", "cnt", if1.match_cnt, 3);
         end
      end
      chk("sat", "pulses", pulses, 8);
      tick();
      chk("sat", "idle_cnt", if1.match_cnt, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_scan_ctrl.md
# seq_scan_ctrl

Scan controller for the serial pattern detector path. It accepts a parallel word on a start request and runs a fixed sequence: reset the detector, then shift the word out MSB-first one bit per clock, then signal completion. During the scan it tracks an internal overlapping match of a programmable pattern (default 11001) and counts the hits, so a downstream Moore detector driven from `ser_bit` can be checked against `match_cnt`.

## Interface
- `WORD_W`, 16: width of the scanned word, ≥ `PAT_W`.
- `PAT_W`, 5: pattern length, ≥ 2.
- `PAT`, 5'b11001: pattern, matched MSB-first (first received bit = `PAT[PAT_W-1]`).
- `CNT_W`, 5: match counter width; the counter saturates.

- `CLK` in 1: clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `start` in 1: scan request, sampled only in IDLE.
- `abort` in 1: synchronous abort, effective in CLR or SHIFT.
- `din` in `WORD_W`: word to scan, captured when `start` is accepted.
- `busy` out 1: high in CLR and SHIFT.
- `det_rst` out 1: one-cycle reset pulse to the external detector (CLR state).
- `ser_bit` out 1: current serial bit, equal to the MSB of the shift register.
- `ser_valid` out 1: high in SHIFT only.
- `match_pulse` out 1: registered, high for one cycle after a bit completes `PAT`.
- `match_cnt` out `CNT_W`: number of matches in the current or last scan.
- `done` out 1: one-cycle completion pulse (DONE state).

## Operation
- Clock and reset: one clock (`CLK`); reset (`RESET`) is synchronous and active-high.
- States:
  - IDLE: `start`=1 captures `din` into the shift register and moves to CLR; `start`=0 stays in IDLE.
  - CLR: `det_rst`=1, `match_cnt`←0, history and bit counter ←0. Next state is SHIFT.
  - SHIFT: asserted for exactly `WORD_W` cycles.
    - Each cycle the shift register shifts left by 1 (zero fill) and the history takes `{hist[PAT_W-2:0], ser_bit}`.
    - The bit counter increments.
    - After the `WORD_W`-th bit the next state is DONE.
  - DONE: `done`=1 for one cycle. Next state is IDLE.
- Match rule (SHIFT only):
  - `hist_next = {hist[PAT_W-2:0], ser_bit}`.
  - A match requires that at least `PAT_W` bits of the current scan have been shifted, including the current bit, and that `hist_next == PAT`.
  - On a match, `match_pulse`←1 at the same edge. `match_cnt`←`match_cnt`+1, saturating at 2^`CNT_W`−1.
- Overlap: overlapping matches are counted, so 110011001 gives 2 hits. History is cleared in CLR, so a match never straddles two scans.
- `match_cnt` holds its value from DONE until the next CLR, and is readable in IDLE.
- `start` while `busy` or in DONE is ignored, with no queuing.
- `abort`=1 in CLR or SHIFT: next state is IDLE, no `done` pulse, and `match_cnt` holds its partial value. `abort` in IDLE or DONE is ignored. If `abort` and `start` are both high in IDLE, `start` wins.
- `RESET` at any point overrides everything. At the next edge: state=IDLE, and all outputs, the shift register, history, bit counter and `match_cnt` are 0.

## Timing
- Reset values: `busy`=0, `det_rst`=0, `ser_bit`=0, `ser_valid`=0, `match_pulse`=0, `match_cnt`=0, `done`=0.
- With `start` sampled at edge k:
  - CLR is cycle k+1.
  - SHIFT runs from cycle k+2 to k+`WORD_W`+1.
  - DONE is cycle k+`WORD_W`+2, which is 18 cycles after the start edge at the defaults.
- Back-to-back scans: `start` held high through DONE is accepted in the IDLE cycle that follows, so the minimum period is `WORD_W`+3 cycles.
- `match_pulse` for the bit shifted in cycle t is seen in cycle t+1. The last bit's pulse coincides with `done`, and `match_cnt` is final in the DONE cycle.
- `det_rst` precedes the first `ser_valid` by exactly one cycle.

## Test plan
- Single match: `din`=16'hC800 → in each scan `det_rst` precedes `ser_valid` by one cycle, `ser_valid` is high for 16 cycles, one `match_pulse` (cycle after the 5th bit), `match_cnt`=1, `done` 18 cycles after start.
- Overlap: `din`=16'hCC80 → `match_pulse` after bits 5 and 9, `match_cnt`=2. Repeat with 16'h0000 → no `match_pulse`, `match_cnt`=0 (cleared in CLR).
- Saturation with `PAT_W`=2, `PAT`=2'b10, `CNT_W`=2, `din`=16'hAAAA → 8 `match_pulse`s, `match_cnt` sticks at 3.
- Straddle and back-to-back: scan 16'h000C, then 16'h8000 with `start` held high → no match, `match_cnt`=0 both times, second CLR one cycle after the first DONE.
- Interrupts:
  - `abort` at the 6th SHIFT cycle of 16'hCC80 → IDLE next cycle, no `done`, `match_cnt`=1.
  - `RESET` mid-SHIFT → all outputs 0 next cycle.
  - `start` pulsed while `busy` → ignored.
